// File: rtl/barrel_shifter_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
package barrel_shifter_pkg;

    // Operation encoding. Values 3'b101..3'b111 are reserved and pass data through.
    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // Number of log2 mux levels (also the shift-amount width).
    function automatic int calc_sw(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Register stages: one after every lpr levels, the last level always registered.
    function automatic int calc_lat(input int sw, input int lpr);
        int lat;
        lat = (sw + lpr - 1) / lpr;
        return (lat < 1) ? 1 : lat;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// One combinational mux level: optionally moves the word by a fixed 2^i positions.
module shift_level
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    // Select the shifted/rotated word for this level, or pass through.
    always_comb begin
        // NOTE: default assignment first so every path drives result (no latch).
        result = data;
        if (en) begin
            case (op_e'(op))
                OP_SLL:  result = data << AMT;
                OP_SRL:  result = data >> AMT;
                OP_SRA:  result = $signed(data) >>> AMT;
                OP_ROL:  result = (data << AMT) | (data >> (WIDTH - AMT));
                OP_ROR:  result = (data >> AMT) | (data << (WIDTH - AMT));
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2 mux levels split into register stages,
// with a valid/ready handshake, collapsing bubbles and a carried tag.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int  WIDTH          = 32,
    parameter int  LEVELS_PER_REG = 2,
    parameter int  TAG_W          = 4,
    localparam int SW             = calc_sw(WIDTH),
    localparam int LAT            = calc_lat(SW, LEVELS_PER_REG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shift,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Stage register contents.
    logic             stg_valid [LAT];
    logic [WIDTH-1:0] stg_data  [LAT];
    logic [SW-1:0]    stg_shift [LAT];
    logic [2:0]       stg_op    [LAT];
    logic [TAG_W-1:0] stg_tag   [LAT];
    logic             stg_adv   [LAT];

    // What feeds each stage: the input port for stage 0, else the previous stage.
    logic             src_valid [LAT];
    logic [WIDTH-1:0] src_data  [LAT];
    logic [SW-1:0]    src_shift [LAT];
    logic [2:0]       src_op    [LAT];
    logic [TAG_W-1:0] src_tag   [LAT];
    logic [WIDTH-1:0] nxt_data  [LAT];

    logic [WIDTH-1:0] lvl_in  [SW];
    logic [WIDTH-1:0] lvl_out [SW];

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int LAST_LVL =
            (((s + 1) * LEVELS_PER_REG < SW) ? (s + 1) * LEVELS_PER_REG : SW) - 1;

        if (s == 0) begin : g_first
            assign src_valid[s] = in_valid;
            assign src_data[s]  = in_data;
            assign src_shift[s] = in_shift;
            assign src_op[s]    = in_op;
            assign src_tag[s]   = in_tag;
        end else begin : g_chain
            assign src_valid[s] = stg_valid[s-1];
            assign src_data[s]  = stg_data[s-1];
            assign src_shift[s] = stg_shift[s-1];
            assign src_op[s]    = stg_op[s-1];
            assign src_tag[s]   = stg_tag[s-1];
        end

        // A stage may load when empty or when its contents move on this cycle.
        if (s == LAT - 1) begin : g_out_adv
            assign stg_adv[s] = !stg_valid[s] || out_ready;
        end else begin : g_mid_adv
            assign stg_adv[s] = !stg_valid[s] || stg_adv[s+1];
        end

        assign nxt_data[s] = lvl_out[LAST_LVL];
    end

    for (genvar i = 0; i < SW; i++) begin : g_level
        localparam int S = i / LEVELS_PER_REG;

        if (i % LEVELS_PER_REG == 0) begin : g_head
            assign lvl_in[i] = src_data[S];
        end else begin : g_body
            assign lvl_in[i] = lvl_out[i-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .AMT   (1 << i)
        ) u_level (
            .data   (lvl_in[i]),
            .en     (src_shift[S][i]),
            .op     (src_op[S]),
            .result (lvl_out[i])
        );
    end

    // Stage registers: load on advance, drop all valids on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage payload registers are reset too, so out_data/out_tag read 0 out of reset.
            for (int s = 0; s < LAT; s++) begin
                stg_valid[s] <= 1'b0;
                stg_data[s]  <= '0;
                stg_shift[s] <= '0;
                stg_op[s]    <= '0;
                stg_tag[s]   <= '0;
            end
        end else begin
            // NOTE: non-blocking so each stage samples its predecessor's pre-edge value.
            for (int s = 0; s < LAT; s++) begin
                if (flush) begin
                    stg_valid[s] <= 1'b0;
                end else if (stg_adv[s]) begin
                    stg_valid[s] <= src_valid[s];
                    stg_data[s]  <= nxt_data[s];
                    stg_shift[s] <= src_shift[s];
                    stg_op[s]    <= src_op[s];
                    stg_tag[s]   <= src_tag[s];
                end
            end
        end
    end

    // The output stage's shift/op copies have no consumer; kept for a uniform stage layout.
    logic unused_ok;
    assign unused_ok = ^{stg_shift[LAT-1], stg_op[LAT-1]};

    assign in_ready  = flush || stg_adv[0];
    assign out_valid = stg_valid[LAT-1];
    assign out_data  = stg_data[LAT-1];
    assign out_tag   = stg_tag[LAT-1];

endmodule
